// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: word-organised little-endian RAM behind valid/ready
// request and response channels. Define DMEM_BACK_TO_BACK_EN to overlap response handshake with next accept.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsign,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        up;
    logic        accept;
    logic        rsp_hs;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] idx;
    logic [AW-1:0] widx;
    logic        misalign;
    logic        err;
    logic [4:0]  sh;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] mask;
    logic [31:0] merged;

    assign accept = req_valid & req_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    // Address decode and error detection, evaluated on the live request.
    assign idx  = (req_addr - BASE_ADDR) >> 2;
    assign widx = idx[AW-1:0];
    assign sh   = {req_addr[1:0], 3'b000};

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign err = (req_size == 2'd3) | misalign | (idx >= 32'(DEPTH_WORDS));

    assign word    = mem[widx];
    assign shifted = word >> sh;

    always_comb begin
        load_data = shifted;
        case (req_size)
            2'd0: load_data = req_unsign ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_data = req_unsign ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (req_size)
            2'd0:    mask = 32'h0000_00FF << sh;
            2'd1:    mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
    end

    assign merged = (word & ~mask) | ((req_wdata << sh) & mask);

    // Stores commit at their accept edge; RAM is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (accept && req_rw && !err)
            mem[widx] <= merged;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == 4'(LATENCY - 1)) state_nxt = RESP;
            RESP: if (rsp_hs)
                      state_nxt = accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == RESP);
        req_ready = 1'b0;
`ifdef DMEM_BACK_TO_BACK_EN
        req_ready = up & ((state == IDLE) | ((state == RESP) & rsp_ready));
`else
        req_ready = up & (state == IDLE);
`endif
    end

    // Holds req_ready low for the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) up <= 1'b0;
        else        up <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              cnt <= 4'd0;
        else if (accept)         cnt <= 4'd1;
        else if (state == WAIT)  cnt <= cnt + 4'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_err   <= err;
            rsp_rdata <= (err | req_rw) ? 32'b0 : load_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
module tb_dmem_responder;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 256;
`ifdef DMEM_BACK_TO_BACK_EN
    localparam int GAP = LAT;
`else
    localparam int GAP = LAT + 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic [1:0]  req_size = 2'b0;
    logic        req_unsign = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] mref [0:4*DEPTH-1];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsign(req_unsign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    // Reference: memory as a flat byte array, accesses assembled byte by byte.
    function automatic void model(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  output logic [31:0] rd, output logic er);
        logic [31:0] off;
        int n;
        off = addr - BASE;
        n   = 1 << size;
        rd  = 32'b0;
        er  = (size == 2'd3) || ((addr % n) != 0) || (off >= 32'(4 * DEPTH));
        if (er) return;
        if (rw) begin
            for (int i = 0; i < n; i++) mref[int'(off) + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) rd |= 32'(mref[int'(off) + i]) << (8 * i);
            if (!uns && n < 4 && rd[8*n-1]) rd |= 32'hFFFF_FFFF << (8 * n);
        end
    endfunction

    // One full transaction; starts and ends at a negedge. lat = negedges from accept to rsp_valid.
    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        req_rw = rw; req_addr = addr; req_wdata = wdata; req_size = size; req_unsign = uns;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clock); lat++; end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clock);
            tests++;
            if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'b0) begin
                fails++;
                $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h, want all 0",
                         req_ready, rsp_valid, rsp_err, rsp_rdata);
            end
        end
        reset = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++; $display("FAIL reset_release_ready: got %b want 0", req_ready);
        end
        @(negedge clock);
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_first_edge: got rdy=%b vld=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic er, eer; int lat;
        model(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, erd, eer);
        do_req(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, er, lat);
        tests++;
        if (lat !== LAT || er !== 1'b0 || rd !== 32'b0) begin
            fails++; $display("FAIL store_word: lat=%0d err=%b rdata=%h want %0d/0/0", lat, er, rd, LAT);
        end
        do_req(1'b0, BASE + 32'h10, 32'h0, 2'd2, 1'b0, rd, er, lat);
        tests++;
        if (lat !== LAT || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL load_word: lat=%0d err=%b rdata=%h want %0d/0/deadbeef", lat, er, rd, LAT);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd; logic er, eer; int lat;
        model(1'b1, BASE + 32'h13, 32'h80, 2'd0, 1'b0, erd, eer);
        do_req(1'b1, BASE + 32'h13, 32'h80, 2'd0, 1'b0, rd, er, lat);
        do_req(1'b0, BASE + 32'h13, 32'h0, 2'd0, 1'b0, rd, er, lat);
        tests++;
        if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin
            fails++; $display("FAIL load_byte_signed: rdata=%h err=%b want ffffff80/0", rd, er);
        end
        do_req(1'b0, BASE + 32'h13, 32'h0, 2'd0, 1'b1, rd, er, lat);
        tests++;
        if (rd !== 32'h0000_0080 || er !== 1'b0) begin
            fails++; $display("FAIL load_byte_unsigned: rdata=%h err=%b want 00000080/0", rd, er);
        end
        do_req(1'b0, BASE + 32'h10, 32'h0, 2'd2, 1'b1, rd, er, lat);
        tests++;
        if (rd !== 32'h80AD_BEEF || er !== 1'b0) begin
            fails++; $display("FAIL load_word_merged: rdata=%h err=%b want 80adbeef/0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        logic        rw_t   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] addr_t [4] = '{BASE + 32'h11, BASE + 32'h400, BASE + 32'h10, 32'h00FF_FFFC};
        logic [1:0]  size_t [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 4; i++) begin
            do_req(rw_t[i], addr_t[i], 32'h1234_5678, size_t[i], 1'b0, rd, er, lat);
            tests++;
            if (er !== 1'b1 || rd !== 32'b0 || lat !== LAT) begin
                fails++; $display("FAIL error_case_%0d: err=%b rdata=%h lat=%0d want 1/0/%0d", i, er, rd, lat, LAT);
            end
        end
        do_req(1'b0, BASE + 32'h10, 32'h0, 2'd2, 1'b0, rd, er, lat);
        tests++;
        if (rd !== 32'h80AD_BEEF || er !== 1'b0) begin
            fails++; $display("FAIL error_no_write: rdata=%h err=%b want 80adbeef/0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held; int n;
        n = 0;
        req_rw = 1'b0; req_addr = BASE + 32'h10; req_size = 2'd2; req_unsign = 1'b0;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
        held = rsp_rdata;
        repeat (5) begin
            @(negedge clock);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80AD_BEEF || rsp_rdata !== held || req_ready !== 1'b0) begin
                fails++; $display("FAIL backpressure_hold: vld=%b rdata=%h rdy=%b want 1/80adbeef/0",
                                  rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL backpressure_release: vld=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    // Continuous valid and rsp_ready: measures spacing between accepts.
    task automatic test_back_to_back();
        logic        rw_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] addr_t [4] = '{BASE + 32'h20, BASE + 32'h20, BASE + 32'h21, BASE + 32'h20};
        logic [31:0] wd_t   [4] = '{32'h1122_3344, 32'h0, 32'hAA, 32'h0};
        logic [1:0]  size_t [4] = '{2'd2, 2'd2, 2'd0, 2'd2};
        int acc [$];
        logic [31:0] expq [$];
        logic [31:0] erd; logic eer;
        int i, cyc, nrsp; bit pend;
        i = 0; cyc = 0; nrsp = 0; pend = 0;
        rsp_ready = 1'b1;
        req_rw = rw_t[0]; req_addr = addr_t[0]; req_wdata = wd_t[0]; req_size = size_t[0]; req_unsign = 1'b0;
        req_valid = 1'b1;
        while (nrsp < 4 && cyc < 60) begin
            if (pend) begin
                pend = 0; i++;
                if (i < 4) begin
                    req_rw = rw_t[i]; req_addr = addr_t[i]; req_wdata = wd_t[i]; req_size = size_t[i];
                end else req_valid = 1'b0;
            end
            if (rsp_valid) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++; $display("FAIL b2b_extra_rsp: rdata=%h with no pending request", rsp_rdata);
                end else begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    if (rsp_rdata !== e || rsp_err !== 1'b0) begin
                        fails++; $display("FAIL b2b_rsp_%0d: rdata=%h err=%b want %h/0", nrsp, rsp_rdata, rsp_err, e);
                    end
                end
                nrsp++;
            end
            if (req_valid && req_ready) begin
                model(req_rw, req_addr, req_wdata, req_size, 1'b0, erd, eer);
                expq.push_back(erd);
                acc.push_back(cyc);
                pend = 1;
            end
            @(negedge clock);
            cyc++;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        tests++;
        if (acc.size() != 4 || nrsp != 4) begin
            fails++; $display("FAIL b2b_count: accepts=%0d responses=%0d want 4/4", acc.size(), nrsp);
        end else begin
            for (int k = 1; k < 4; k++) begin
                tests++;
                if (acc[k] - acc[k-1] != GAP) begin
                    fails++; $display("FAIL b2b_gap_%0d: got %0d cycles want %0d", k, acc[k] - acc[k-1], GAP);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd, erd; logic er, eer; int lat, n;
        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            req_rw = (pass == 1); req_addr = BASE + 32'h30; req_wdata = 32'hCAFE_F00D;
            req_size = 2'd2; req_unsign = 1'b0;
            req_valid = 1'b1;
            while (!req_ready && n < 20) begin @(negedge clock); n++; end
            if (pass == 1) model(1'b1, BASE + 32'h30, 32'hCAFE_F00D, 2'd2, 1'b0, erd, eer);
            @(posedge clock);
            @(negedge clock);
            req_valid = 1'b0;
            reset = 1'b0;
            repeat (2) @(negedge clock);
            reset = 1'b1;
            repeat (4) begin
                @(negedge clock);
                tests++;
                if (rsp_valid !== 1'b0) begin
                    fails++; $display("FAIL reset_midop_%0d: rsp_valid=%b want 0", pass, rsp_valid);
                end
            end
        end
        do_req(1'b0, BASE + 32'h30, 32'h0, 2'd2, 1'b0, rd, er, lat);
        tests++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            fails++; $display("FAIL reset_store_kept: rdata=%h err=%b want cafef00d/0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd; logic er, eer, rw, uns; logic [1:0] size; int lat;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model(1'b1, BASE + 32'(4 * w), wd, 2'd2, 1'b0, erd, eer);
            do_req(1'b1, BASE + 32'(4 * w), wd, 2'd2, 1'b0, rd, er, lat);
        end
        for (int t = 0; t < 80; t++) begin
            rw   = $urandom_range(0, 1);
            uns  = $urandom_range(0, 1);
            size = 2'($urandom_range(0, 3));
            wd   = $urandom;
            case ($urandom_range(0, 9))
                0:       addr = BASE + 32'h400 + 32'($urandom_range(0, 255));
                1:       addr = BASE - 32'($urandom_range(1, 16));
                default: addr = BASE + 32'($urandom_range(0, 63));
            endcase
            model(rw, addr, wd, size, uns, erd, eer);
            do_req(rw, addr, wd, size, uns, rd, er, lat);
            tests++;
            if (rd !== erd || er !== eer || lat !== LAT) begin
                fails++;
                $display("FAIL random_%0d: rw=%b addr=%h size=%0d uns=%b got rdata=%h err=%b lat=%0d want %h/%b/%0d",
                         t, rw, addr, size, uns, rd, er, lat, erd, eer, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
